// File: rtl/spi_frame_tx_pkg.sv
// Shared constants, FSM state type and gap lookup for the spi_frame_tx link transmitter.
package spi_frame_pkg;

    localparam int                WORD_W    = 14;
    localparam logic [WORD_W-1:0] HEADER    = 14'h0FFF;

    localparam int HALF_SCK  = 8;
    localparam int CS_LEAD   = 16;
    localparam int CS_LAG    = 16;
    localparam int GAP_SHORT = 24;
    localparam int GAP_LONG  = 168;
    localparam int GAP_FRAME = 3384;

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, LAG, GAP} state_t;

    // cs-high time that follows word word_idx (0 = header .. 4 = CH4)
    function automatic int gap_len(input logic [2:0] word_idx);
        case (word_idx)
            3'd0, 3'd2: return GAP_SHORT;
            3'd1, 3'd3: return GAP_LONG;
            default:    return GAP_FRAME;
        endcase
    endfunction

endpackage

// File: rtl/spi_frame_tx_if.sv
// Sample-set handshake between the capture logic (master) and spi_frame_tx (slave).
interface spi_frame_tx_if;

    logic                             in_valid;
    logic                             in_ready;
    logic [spi_frame_pkg::WORD_W-1:0] in_ch1;
    logic [spi_frame_pkg::WORD_W-1:0] in_ch2;
    logic [spi_frame_pkg::WORD_W-1:0] in_ch3;
    logic [spi_frame_pkg::WORD_W-1:0] in_ch4;

    modport master (output in_valid, in_ch1, in_ch2, in_ch3, in_ch4, input in_ready);
    modport slave  (input in_valid, in_ch1, in_ch2, in_ch3, in_ch4, output in_ready);

endinterface

// File: rtl/spi_frame_tx_word_shifter.sv
// Shifts one WORD_W word out MSB first; sck toggles on each half-period tick from the parent.
module spi_word_shifter
    import spi_frame_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic              tick,
    input  logic [WORD_W-1:0] word,
    output logic              sck,
    output logic              mosi,
    output logic              done
);

    logic [WORD_W-1:0] sr_reg;
    logic              sck_reg;
    logic [3:0]        bit_reg;

    // The high half of the last bit ends the word; mosi keeps bit 0 afterwards.
    assign done = tick && sck_reg && (bit_reg == 4'd0);
    assign sck  = sck_reg;
    assign mosi = sr_reg[WORD_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_reg  <= '0;
            sck_reg <= 1'b0;
            bit_reg <= '0;
        end else if (clr) begin
            sr_reg  <= '0;
            sck_reg <= 1'b0;
            bit_reg <= '0;
        end else if (load) begin
            sr_reg  <= word;
            sck_reg <= 1'b0;
            bit_reg <= 4'(WORD_W - 1);
        end else if (tick) begin
            if (!sck_reg) begin
                sck_reg <= 1'b1;
            end else begin
                sck_reg <= 1'b0;
                if (bit_reg != 4'd0) begin
                    sr_reg  <= {sr_reg[WORD_W-2:0], 1'b0};
                    bit_reg <= bit_reg - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_frame_tx.sv
// SPI frame transmitter: header + CH1..CH4 as five cs-framed 14-bit words with fixed gaps.
// Optional SPI_FRAME_TX_REPEAT_EN: resend the last sample set when none is offered at frame end.
module spi_frame_tx
    import spi_frame_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    spi_frame_tx_if.slave link,
    output logic          sck,
    output logic          mosi,
    output logic          cs,
    output logic          busy,
    output logic          frame_done
);

    localparam int MAX_A   = (CS_LEAD > CS_LAG) ? CS_LEAD : CS_LAG;
    localparam int MAX_B   = (MAX_A > HALF_SCK) ? MAX_A : HALF_SCK;
    localparam int CNT_MAX = (MAX_B > GAP_FRAME) ? MAX_B : GAP_FRAME;
    localparam int CNT_W   = $clog2(CNT_MAX);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_last;
    logic [2:0]        idx_reg, idx_next;
    logic [WORD_W-1:0] samp_reg [4];
    logic [WORD_W-1:0] word_next;
    logic              cs_reg, busy_reg, ready_reg, done_reg;
    logic              accept, load, clr, tick, last, done_next, sh_done;
    int                cur_len;

    assign link.in_ready = ready_reg;
    assign cs            = cs_reg;
    assign busy          = busy_reg;
    assign frame_done    = done_reg;

    always_comb begin
        cur_len = 1;
        case (state_reg)
            LEAD:    cur_len = CS_LEAD;
            SHIFT:   cur_len = HALF_SCK;
            LAG:     cur_len = CS_LAG;
            GAP:     cur_len = gap_len(idx_reg);
            default: cur_len = 1;
        endcase
        cnt_last = CNT_W'(cur_len - 1);
        last     = (cnt_reg == cnt_last);
        tick     = (state_reg == SHIFT) && last;
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        accept     = 1'b0;
        load       = 1'b0;
        clr        = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: if (link.in_valid && ready_reg) begin
                accept     = 1'b1;
                load       = 1'b1;
                idx_next   = 3'd0;
                state_next = LEAD;
            end
            LEAD:  if (last) state_next = SHIFT;
            SHIFT: if (sh_done) state_next = LAG;
            LAG: if (last) begin
                clr        = 1'b1;
                state_next = GAP;
            end
            GAP: if (last) begin
                if (idx_reg == 3'd4) begin
                    done_next = 1'b1;
                    idx_next  = 3'd0;
`ifdef SPI_FRAME_TX_REPEAT_EN
                    // A pending sample set wins: go through IDLE so it is handshaken.
                    if (!link.in_valid) begin
                        load       = 1'b1;
                        state_next = LEAD;
                    end else begin
                        state_next = IDLE;
                    end
`else
                    state_next = IDLE;
`endif
                end else begin
                    idx_next   = idx_reg + 3'd1;
                    load       = 1'b1;
                    state_next = LEAD;
                end
            end
            default: state_next = IDLE;
        endcase

        // Phase counter restarts on every state change and every sck half period.
        if ((state_next != state_reg) || tick || (state_reg == IDLE))
            cnt_next = '0;
        else
            cnt_next = cnt_reg + 1'b1;

        case (idx_next)
            3'd1:    word_next = samp_reg[0];
            3'd2:    word_next = samp_reg[1];
            3'd3:    word_next = samp_reg[2];
            3'd4:    word_next = samp_reg[3];
            default: word_next = HEADER;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            cs_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            cs_reg    <= !(state_next inside {LEAD, SHIFT, LAG});
            busy_reg  <= (state_next != IDLE);
            ready_reg <= (state_next == IDLE);
            done_reg  <= done_next;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int i = 0; i < 4; i++) samp_reg[i] <= '0;
        end else if (accept) begin
            samp_reg[0] <= link.in_ch1;
            samp_reg[1] <= link.in_ch2;
            samp_reg[2] <= link.in_ch3;
            samp_reg[3] <= link.in_ch4;
        end
    end

    spi_word_shifter u_shifter (
        .clk  (clk),
        .rst  (rstn),
        .load (load),
        .clr  (clr),
        .tick (tick),
        .word (word_next),
        .sck  (sck),
        .mosi (mosi),
        .done (sh_done)
    );

endmodule

// File: tb/tb_spi_frame_tx.sv
// Directed bench for spi_frame_tx: decodes the SPI link on sck rising edges and checks words and timing.
module tb_spi_frame_tx;
    import spi_frame_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    logic sck, mosi, cs, busy, frame_done;

    spi_frame_tx_if link();

    spi_frame_tx dut (
        .clk        (clk),
        .rstn       (rstn),
        .link       (link),
        .sck        (sck),
        .mosi       (mosi),
        .cs         (cs),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // ---------------- SPI monitor ----------------
    logic [13:0] rx_q[$];
    int          nbit_q[$], low_q[$], rise_q[$], gap_q[$], lead_q[$];
    logic [13:0] exp_q[$];
    logic [13:0] sh = '0;
    int          nb = 0;
    int          bad_space = 0;
    time         t_fall = 0, t_rise = 0, t_last = 0;
    logic        mon_first = 1'b1;

    always @(negedge cs) begin
        if (!mon_first) gap_q.push_back(int'((($time - t_rise)) / 10));
        mon_first = 1'b0;
        t_fall    = $time;
        nb        = 0;
        sh        = '0;
        #1 lead_q.push_back(int'(mosi));
    end

    always @(posedge sck) begin
        if (cs === 1'b0) begin
            if (nb == 0) rise_q.push_back(int'(($time - t_fall) / 10));
            else if (($time - t_last) != 160) bad_space++;
            t_last = $time;
            sh     = {sh[12:0], mosi};
            nb++;
        end
    end

    always @(posedge cs) begin
        low_q.push_back(int'(($time - t_fall) / 10));
        rx_q.push_back(sh);
        nbit_q.push_back(nb);
        t_rise = $time;
    end

    task automatic mon_clear();
        rx_q.delete(); nbit_q.delete(); low_q.delete(); rise_q.delete();
        gap_q.delete(); lead_q.delete();
        bad_space = 0;
        mon_first = 1'b1;
    endtask

    // ---------------- stimulus helpers ----------------
    time t_acc, t_done;

    task automatic offer(input logic [13:0] c1, input logic [13:0] c2,
                         input logic [13:0] c3, input logic [13:0] c4);
        int k = 0;
        while (link.in_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_offer", link.in_ready, 1);
        link.in_valid = 1'b1;
        link.in_ch1 = c1; link.in_ch2 = c2; link.in_ch3 = c3; link.in_ch4 = c4;
        exp_q.delete();
        exp_q.push_back(HEADER);
        exp_q.push_back(c1); exp_q.push_back(c2); exp_q.push_back(c3); exp_q.push_back(c4);
        mon_clear();
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        link.in_valid = 1'b0;
        $display("[TB] accept %h %h %h %h", c1, c2, c3, c4);
        check("accept_busy", busy, 1);
        check("accept_ready", link.in_ready, 0);
        check("accept_cs", cs, 0);
    endtask

    task automatic wait_done(input string tag, input logic exp_ready);
        int k = 0;
        while (frame_done !== 1'b1 && k < 6000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_seen"}, frame_done, 1);
        t_done = $time;
        check({tag, "_frame_len"}, int'((t_done - t_acc) / 10), 5048);
        check({tag, "_frame_gap"}, int'((t_done - t_rise) / 10), GAP_FRAME);
        check({tag, "_ready_at_done"}, link.in_ready, exp_ready);
        @(negedge clk);
        check({tag, "_done_pulse"}, frame_done, 0);
    endtask

    task automatic check_words(input string tag);
        check({tag, "_nwords"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("%s_word%0d", tag, i), rx_q[i], exp_q[i]);
            check($sformatf("%s_nbits%0d", tag, i), nbit_q[i], WORD_W);
            if (i < lead_q.size())
                check($sformatf("%s_lead_mosi%0d", tag, i), lead_q[i], exp_q[i][13]);
        end
        $display("[TB] %s: %0d words received", tag, rx_q.size());
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int ready_n, done_n;
        int acc_k[$];
        logic signed [13:0] s14;
        int sv;
        logic fd_seen;

        rstn = 1'b1;
        link.in_valid = 1'b0;
        link.in_ch1 = '0; link.in_ch2 = '0; link.in_ch3 = '0; link.in_ch4 = '0;
        repeat (2) @(negedge clk);
        check("rst_cs", cs, 1);
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);
        check("rst_ready", link.in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        rstn = 1'b0;
        check("rel_ready_before_edge", link.in_ready, 0);
        @(negedge clk);
        check("rel_ready", link.in_ready, 1);
        check("rel_cs", cs, 1);

`ifdef SPI_FRAME_TX_REPEAT_EN
        offer(14'h1234, 14'h0002, 14'h3FFE, 14'h2000);
        exp_q.delete();
        for (int f = 0; f < 3; f++) begin
            exp_q.push_back(HEADER); exp_q.push_back(14'h1234); exp_q.push_back(14'h0002);
            exp_q.push_back(14'h3FFE); exp_q.push_back(14'h2000);
        end
        for (int f = 0; f < 3; f++) begin
            wait_done($sformatf("rep%0d", f), 1'b0);
            t_acc = t_done - 5;
        end
        check_words("rep_frames");
        // New sample set held across the next frame end replaces the repeat.
        link.in_valid = 1'b1;
        link.in_ch1 = 14'h0555; link.in_ch2 = 14'h1AAA; link.in_ch3 = 14'h3001; link.in_ch4 = 14'h0100;
        begin
            int k = 0;
            while (frame_done !== 1'b1 && k < 6000) begin
                @(negedge clk);
                k++;
            end
        end
        check("rep_new_done_seen", frame_done, 1);
        check("rep_new_frame_len", int'(($time - t_acc) / 10), 5048);
        check("rep_new_ready", link.in_ready, 1);
        mon_clear();
        exp_q.delete();
        exp_q.push_back(HEADER); exp_q.push_back(14'h0555); exp_q.push_back(14'h1AAA);
        exp_q.push_back(14'h3001); exp_q.push_back(14'h0100);
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        link.in_valid = 1'b0;
        check("rep_new_busy", busy, 1);
        check("rep_new_cs", cs, 0);
        wait_done("rep_new", 1'b0);
        check_words("rep_new");
`else
        // Basic frame with word timing.
        offer(14'h1234, 14'h2ABC, 14'h0001, 14'h3FFF);
        wait_done("t1", 1'b1);
        check_words("t1");
        check("t1_nlow", low_q.size(), 5);
        for (int i = 0; i < low_q.size(); i++) check($sformatf("t1_cs_low%0d", i), low_q[i], 256);
        for (int i = 0; i < rise_q.size(); i++) check($sformatf("t1_first_rise%0d", i), rise_q[i], 24);
        check("t1_sck_spacing_errs", bad_space, 0);
        check("t1_ngaps", gap_q.size(), 4);
        if (gap_q.size() == 4) begin
            check("t1_gap0", gap_q[0], GAP_SHORT);
            check("t1_gap1", gap_q[1], GAP_LONG);
            check("t1_gap2", gap_q[2], GAP_SHORT);
            check("t1_gap3", gap_q[3], GAP_LONG);
        end

        // Negative samples go out as raw two's complement.
        offer(14'h3FFF, 14'h2000, 14'h1555, 14'h0AAA);
        wait_done("neg", 1'b1);
        check_words("neg");
        if (rx_q.size() >= 3) begin
            s14 = rx_q[1]; sv = s14; check("neg_ch1_dn", sv, -1);
            s14 = rx_q[2]; sv = s14; check("neg_ch2_dn", sv, -8192);
        end

        // in_valid held high with changing samples.
        mon_clear();
        exp_q.delete();
        acc_k.delete();
        ready_n = 0;
        done_n  = 0;
        for (int k = 0; k <= 10098; k++) begin
            if (k > 0) @(negedge clk);
            if (frame_done === 1'b1) done_n++;
            if (k < 10098) begin
                link.in_valid = 1'b1;
                link.in_ch1 = 14'(k * 3 + 5);
                link.in_ch2 = 14'(k * 7) ^ 14'h2AAA;
                link.in_ch3 = 14'(k);
                link.in_ch4 = ~14'(k);
            end else begin
                link.in_valid = 1'b0;
            end
            if (link.in_ready === 1'b1) begin
                ready_n++;
                if (link.in_valid) begin
                    acc_k.push_back(k);
                    exp_q.push_back(HEADER);
                    exp_q.push_back(link.in_ch1); exp_q.push_back(link.in_ch2);
                    exp_q.push_back(link.in_ch3); exp_q.push_back(link.in_ch4);
                end
            end
        end
        check("cont_ready_cycles", ready_n, 3);
        check("cont_accepts", acc_k.size(), 2);
        check("cont_done_pulses", done_n, 2);
        if (acc_k.size() == 2) check("cont_accept_spacing", acc_k[1] - acc_k[0], 5049);
        check_words("cont");

        // Reset during bit 6 of CH2 aborts the frame.
        offer(14'h1111, 14'h3FFF, 14'h2222, 14'h0333);
        repeat (842) @(negedge clk);
        check("abort_pre_sck", sck, 1);
        check("abort_pre_mosi", mosi, 1);
        check("abort_pre_cs", cs, 0);
        #2 rstn = 1'b1;
        #1;
        check("abort_cs", cs, 1);
        check("abort_sck", sck, 0);
        check("abort_mosi", mosi, 0);
        check("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("abort_rel_ready", link.in_ready, 1);
        fd_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (frame_done === 1'b1) fd_seen = 1'b1;
            @(negedge clk);
        end
        check("abort_no_done", fd_seen, 0);
        offer(14'h0ABC, 14'h1DEF, 14'h2345, 14'h3210);
        wait_done("post_abort", 1'b1);
        check_words("post_abort");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_frame_tx.md
Name: spi_frame_tx

Overview:
- SPI master transmitter that drives the 4-channel sample link into top_all: sck, mosi and cs (active-low).
- Each accepted frame goes out as 5 words of 14 bits: header 14'h0FFF, then CH1, CH2, CH3, CH4, each MSB first.
- Sits on the ADC-side FPGA. Samples come from the capture logic through a valid/ready handshake.
- All link timing is counted in clk cycles, so the waveform matches the receiver's expected spacing.

Parameters:
- WORD_W, 14, bits per SPI word.
- HEADER, 14'h0FFF, sync word sent first in every frame.
- HALF_SCK, 8, clk cycles per sck half period (80 ns at 100 MHz).
- CS_LEAD, 16, clk cycles from cs falling to the first sck rising edge region (the first low half starts after this).
- CS_LAG, 16, clk cycles from the last sck falling edge to cs rising.
- GAP_SHORT, 24, cs-high gap after the header and after CH2.
- GAP_LONG, 168, cs-high gap after CH1 and after CH3.
- GAP_FRAME, 3384, cs-high gap after CH4, before the next frame may start.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous, active-high reset.
- in_valid  in  1  a sample set is offered.
- in_ready  out  1  block can accept a sample set.
- in_ch1, in_ch2, in_ch3, in_ch4  in  14 each  signed channel samples.
- sck  out  1  SPI clock, idles low.
- mosi  out  1  SPI data, MSB first.
- cs  out  1  chip select, active low.
- busy  out  1  a frame is in progress, including GAP_FRAME.
- frame_done  out  1  one-cycle pulse at the end of GAP_FRAME.

Behaviour:
- Reset values: sck=0, mosi=0, cs=1, in_ready=0, busy=0, frame_done=0, state=IDLE.
- in_ready goes high on the first clk after reset deasserts.
- Reset asserted mid-frame aborts the frame immediately:
  - cs goes to 1 and sck/mosi go to 0 asynchronously.
  - The partial word is discarded. No frame_done pulse.
- Handshake:
  - in_ready=1 only in IDLE.
  - Transfer happens on a clk edge where in_valid & in_ready; the four samples are latched.
  - Next cycle: in_ready=0, busy=1, state=LEAD, cs=0.
- States:
  - IDLE: waits for the handshake.
  - LEAD: cs=0, sck=0 for CS_LEAD cycles. mosi presents bit 13 of the current word from LEAD entry.
  - SHIFT: per bit, sck=0 for HALF_SCK cycles then sck=1 for HALF_SCK cycles. mosi updates only at the start of a low half and is stable across the rising edge. After bit 0's high half: sck=0, go to LAG.
  - LAG: sck=0, mosi holds bit 0, cs=0 for CS_LAG cycles. Then cs=1 and go to GAP.
  - GAP: cs=1 and mosi=0 for the gap chosen by word index (0→SHORT, 1→LONG, 2→SHORT, 3→LONG, 4→FRAME). Word index 0..3 increments and returns to LEAD. Index 4 pulses frame_done and returns to IDLE.
- Word timing:
  - cs low per word = CS_LEAD + 2·HALF_SCK·WORD_W + CS_LAG = 256 clk.
  - Full frame = 5·256 + 24+168+24+168+3384 = 5048 clk from the accept edge to frame_done.
- Samples are sent as raw 14-bit two's complement, with no conversion.
- Inputs change while busy: ignored, because the latched copy is used.
- in_valid held high continuously: the next frame is accepted on the IDLE cycle after frame_done, giving exactly one IDLE cycle between frames.
- Counters: a single phase counter sized for max(GAP_FRAME, CS_LEAD, CS_LAG, HALF_SCK) and a 4-bit bit counter. They must not wrap; each counter reloads on every state change.

Optional Feature:
- Macro: SPI_FRAME_TX_REPEAT_EN.
- Defined: at the end of GAP_FRAME with no in_valid, the block retransmits the last latched sample set.
  - It skips IDLE and goes straight to LEAD; in_ready stays 0 during the repeat.
  - Before any sample set has been accepted, it stays in IDLE.
  - A handshake offered on the frame_done cycle takes priority over the repeat.
- Undefined: the block always returns to IDLE after a frame.

Decomposition:
- Package spi_frame_pkg holds:
  - WORD_W and HEADER.
  - The state enum {IDLE, LEAD, SHIFT, LAG, GAP}.
  - A gap-select function mapping word index to the GAP_* value.
- Sub-module spi_word_shifter: loads one WORD_W word and generates sck/mosi for SHIFT from HALF_SCK, with a done pulse. The parent owns cs, LEAD/LAG/GAP and sequencing.

Test Plan:
- Reset then one frame with CH1=14'h1234, CH2=14'h2ABC, CH3=14'h0001, CH4=14'h3FFF → SPI monitor (sample on sck rising, framed by cs low) decodes 0FFF,1234,2ABC,0001,3FFF. frame_done occurs exactly 5048 clk after the accept.
- Timing check on one word → cs low for 256 clk; 14 sck rising edges spaced 16 clk apart; first rising edge 24 clk after cs falls. Gaps measured 24/168/24/168/3384.
- in_valid held high with CH values changed every cycle → each frame carries the values present at its accept edge. Exactly one in_ready cycle between frames.
- Reset asserted at bit 6 of CH2 → cs=1, sck=0, mosi=0 in the same cycle; in_ready=1 after release; no frame_done; the next frame is intact.
- Negative samples CH1=-1 (14'h3FFF), CH2=-8192 (14'h2000) → a loopback through top_all yields dn values -1 and -8192.
- With SPI_FRAME_TX_REPEAT_EN and a single accepted set → three identical frames back-to-back, each 5048 clk apart. A new in_valid on a frame_done cycle is accepted in place of the repeat.
